// File: rtl/instruction_decoder_pkg.sv
// Shared constants, enums and decode helpers for the nibble-processor instruction decoder.
package instruction_decoder_pkg;

    localparam logic [3:0] SRC_IMM  = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;
    localparam logic [3:0] SRC_ZERO = 4'd10;

    localparam int EN_X0 = 0;
    localparam int EN_X1 = 1;
    localparam int EN_Y0 = 2;
    localparam int EN_Y1 = 3;
    localparam int EN_R  = 4;
    localparam int EN_M  = 5;
    localparam int EN_I  = 6;
    localparam int EN_DM = 7;
    localparam int EN_O  = 8;

    localparam logic [8:0] EN_ALL = 9'h1FF;
`ifdef NOP_CLEAR_EN
    localparam logic [8:0] EN_NOP_CLEAR = 9'h16F;
`endif

    localparam logic [7:0] NOP_C8 = 8'hC8;
    localparam logic [7:0] NOP_CF = 8'hCF;
    localparam logic [7:0] NOP_D8 = 8'hD8;
    localparam logic [7:0] NOP_DF = 8'hDF;

    typedef enum logic [2:0] {
        OP_LOAD,
        OP_MOV,
        OP_ALU,
        OP_JMP,
        OP_JNZ
    } opclass_e;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic opclass_e decode_class(input logic [3:0] opcode);
        opclass_e cls;
        if (!opcode[3])      cls = OP_LOAD;
        else if (!opcode[2]) cls = OP_MOV;
        else if (!opcode[1]) cls = OP_ALU;
        else if (!opcode[0]) cls = OP_JMP;
        else                 cls = OP_JNZ;
        return cls;
    endfunction

    // Destination 4 is o_reg and destination 7 is dm with i post-increment.
    function automatic logic [8:0] dst_enable(input logic [2:0] dst);
        logic [8:0] en;
        en = '0;
        case (dst)
            3'd0: en[EN_X0] = 1'b1;
            3'd1: en[EN_X1] = 1'b1;
            3'd2: en[EN_Y0] = 1'b1;
            3'd3: en[EN_Y1] = 1'b1;
            3'd4: en[EN_O]  = 1'b1;
            3'd5: en[EN_M]  = 1'b1;
            3'd6: en[EN_I]  = 1'b1;
            default: begin
                en[EN_DM] = 1'b1;
                en[EN_I]  = 1'b1;
            end
        endcase
        return en;
    endfunction

endpackage

// File: rtl/instruction_decoder_p_imm_chain.sv
// Immediate accumulator: consecutive LOADs to the same destination shift nibbles into a wide immediate.
module imm_chain
    import instruction_decoder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              commit,
    input  logic              is_load,
    input  logic [2:0]        dst,
    input  logic [3:0]        nibble,
    output logic [DATA_W-1:0] imm_data
);

    generate
        if (DATA_W > 4) begin : g_wide
            // Only the bits that can still shift into a future immediate are kept.
            logic [DATA_W-5:0] acc;
            logic [2:0]        chain_dst;
            logic              chain_live;
            logic              chain_hit;

            assign chain_hit = chain_live && (chain_dst == dst);
            assign imm_data  = chain_hit ? {acc, nibble} : {{(DATA_W-4){1'b0}}, nibble};

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    acc        <= '0;
                    chain_dst  <= '0;
                    chain_live <= 1'b0;
                end else if (commit) begin
                    if (is_load) begin
                        acc        <= imm_data[DATA_W-5:0];
                        chain_dst  <= dst;
                        chain_live <= 1'b1;
                    end else begin
                        chain_live <= 1'b0;
                    end
                end
            end
        end else begin : g_narrow
            assign imm_data = nibble;
        end
    endgenerate

endmodule

// File: rtl/instruction_decoder_p.sv
// Nibble-processor instruction decoder with registered IR, stall, post-reset clear and chained immediates.
// Build option NOP_CLEAR_EN: committed C8/CF clears x0,x1,y0,y1,m,i and o_reg.
module instruction_decoder_p
    import instruction_decoder_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int INIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        next_instr,
    input  logic              instr_valid,
    input  logic              stall,
    output logic              instr_ready,
    output logic [7:0]        ir,
    output logic              ir_valid,
    output logic              init_busy,
    output logic              jmp,
    output logic              jmp_nz,
    output logic              i_sel,
    output logic              x_sel,
    output logic              y_sel,
    output logic [3:0]        source_sel,
    output logic [3:0]        ir_nibble,
    output logic [DATA_W-1:0] imm_data,
    output logic [8:0]        reg_en
);

    localparam int CNT_W = $clog2(INIT_CYCLES + 1);

    state_e     state, next_state;
    logic [CNT_W-1:0] init_cnt, init_cnt_next;
    opclass_e   op;
    logic       commit;
    logic       is_nop;
    logic [2:0] mov_d, mov_s;
    logic [3:0] mov_src;

    assign op        = decode_class(ir[7:4]);
    assign is_nop    = (ir == NOP_C8) || (ir == NOP_CF) || (ir == NOP_D8) || (ir == NOP_DF);
    assign mov_d     = ir[5:3];
    assign mov_s     = ir[2:0];
    assign ir_nibble = ir[3:0];

    always_comb begin
        if (mov_d == mov_s && mov_d == 3'd4) mov_src = 4'd4;
        else if (mov_d == mov_s)             mov_src = SRC_PINS;
        else                                 mov_src = {1'b0, mov_s};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= next_state;
            init_cnt <= init_cnt_next;
        end
    end

    // A bubble still loads ir; ir_valid tells the decode to ignore it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= 8'h00;
            ir_valid <= 1'b0;
        end else if (instr_ready) begin
            ir       <= next_instr;
            ir_valid <= instr_valid;
        end
    end

    always_comb begin
        next_state    = state;
        init_cnt_next = init_cnt;
        instr_ready   = 1'b0;
        init_busy     = 1'b0;
        commit        = 1'b0;
        reg_en        = '0;
        source_sel    = SRC_ZERO;
        i_sel         = 1'b0;
        x_sel         = 1'b0;
        y_sel         = 1'b0;
        jmp           = 1'b0;
        jmp_nz        = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                reg_en    = EN_ALL;
                if (init_cnt == CNT_W'(INIT_CYCLES - 1)) next_state = ST_RUN;
                else init_cnt_next = init_cnt + CNT_W'(1);
            end
            ST_RUN: begin
                instr_ready = !stall;
                commit      = ir_valid && !stall;
                case (op)
                    OP_LOAD: begin
                        source_sel = SRC_IMM;
                        if (commit) begin
                            reg_en = dst_enable(ir[6:4]);
                            i_sel  = (ir[6:4] == 3'd7);
                        end
                    end
                    OP_MOV: begin
                        source_sel = mov_src;
                        if (commit) begin
                            reg_en = dst_enable(mov_d);
                            if (mov_s == 3'd7) reg_en[EN_I] = 1'b1;
                            i_sel = (mov_d == 3'd7 || mov_s == 3'd7) && (mov_d != 3'd6);
                        end
                    end
                    OP_ALU: begin
                        x_sel = ir[4];
                        y_sel = ir[3];
                        if (commit && !is_nop) reg_en[EN_R] = 1'b1;
`ifdef NOP_CLEAR_EN
                        if (commit && (ir == NOP_C8 || ir == NOP_CF)) begin
                            source_sel = SRC_ZERO;
                            reg_en     = EN_NOP_CLEAR;
                        end
`endif
                    end
                    OP_JMP:  jmp    = commit;
                    OP_JNZ:  jmp_nz = commit;
                    default: ;
                endcase
            end
            default: next_state = ST_INIT;
        endcase
    end

    imm_chain #(
        .DATA_W(DATA_W)
    ) u_imm_chain (
        .clk      (clk),
        .reset_n  (reset_n),
        .commit   (commit),
        .is_load  (op == OP_LOAD),
        .dst      (ir[6:4]),
        .nibble   (ir[3:0]),
        .imm_data (imm_data)
    );

endmodule
